seq_div4: RTL and testbench

SEQ_DIV4 -- requirements
Module: seq_div4

---
 rtl/seq_div4_pkg.sv | 15 +
 rtl/seq_div4_step.sv | 24 ++
 rtl/seq_div4.sv | 170 +++++++++++++++++
 tb/tb_seq_div4.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div4_pkg.sv
// Shared definitions for the seq_div4 sequential divider: FSM states,
// iteration count and the divide-by-zero quotient pattern.
package seq_div4_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int ITER_CNT = 8;
  localparam int CNT_W    = 3;
  localparam logic [7:0] DBZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/seq_div4_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// trial-subtract the divisor, keep the difference only if it is non-negative.
module seq_div4_step #(
  parameter int DVR_W = 4
) (
  input  logic [DVR_W:0]   pr_in,
  input  logic             bit_in,
  input  logic [DVR_W-1:0] divisor,
  output logic [DVR_W:0]   pr_out,
  output logic             q_bit
);

  logic [DVR_W+1:0] trial;
  logic [DVR_W+1:0] diff;

  always_comb begin
    trial  = {pr_in, bit_in};
    diff   = trial - {2'b00, divisor};
    // The top bit of diff is the borrow: set means the subtraction went negative.
    q_bit  = ~diff[DVR_W+1];
    pr_out = q_bit ? diff[DVR_W:0] : trial[DVR_W:0];
  end

endmodule

// File: rtl/seq_div4.sv
// Sequential restoring radix-2 divider, one quotient bit per cycle.
// Optional signed (truncate-toward-zero) operation with SEQ_DIV4_SIGNED_EN.
module seq_div4
  import seq_div4_pkg::*;
#(
  parameter int DVD_W = 8,
  parameter int DVR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVR_W-1:0] divisor,
`ifdef SEQ_DIV4_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVR_W-1:0] remainder,
  output logic             dbz
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVD_W-1:0] dq_q, dq_d;
  logic [DVR_W:0]   pr_q, pr_d;
  logic [DVR_W-1:0] dvr_q, dvr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVR_W-1:0] rem_q, rem_d;
`ifdef SEQ_DIV4_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic [DVR_W:0]   pr_nxt;
  logic             q_bit;
  logic [DVD_W-1:0] quo_raw;
  logic [DVR_W-1:0] rem_raw;

`ifdef SEQ_DIV4_SIGNED_EN
  function automatic logic [DVD_W-1:0] abs_dvd(input logic [DVD_W-1:0] v, input logic en);
    return (en && v[DVD_W-1]) ? -v : v;
  endfunction

  function automatic logic [DVR_W-1:0] abs_dvr(input logic [DVR_W-1:0] v, input logic en);
    return (en && v[DVR_W-1]) ? -v : v;
  endfunction
`endif

  seq_div4_step #(.DVR_W(DVR_W)) u_step (
    .pr_in   (pr_q),
    .bit_in  (dq_q[DVD_W-1]),
    .divisor (dvr_q),
    .pr_out  (pr_nxt),
    .q_bit   (q_bit)
  );

  // dq_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
  always_comb begin
    quo_raw   = {dq_q[DVD_W-2:0], q_bit};
    rem_raw   = pr_nxt[DVR_W-1:0];
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    pr_d      = pr_q;
    dvr_d     = dvr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
`ifdef SEQ_DIV4_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pr_d  = '0;
          cnt_d = '0;
`ifdef SEQ_DIV4_SIGNED_EN
          dq_d      = abs_dvd(dividend, signed_mode);
          dvr_d     = abs_dvr(divisor, signed_mode);
          neg_quo_d = signed_mode & (dividend[DVD_W-1] ^ divisor[DVR_W-1]);
          neg_rem_d = signed_mode & dividend[DVD_W-1];
`else
          dq_d  = dividend;
          dvr_d = divisor;
`endif
          if (divisor == '0) begin
            // Keep the raw dividend so its low bits can be reported as the remainder.
            dq_d    = dividend;
            dvr_d   = '0;
            state_d = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        dq_d  = quo_raw;
        pr_d  = pr_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
`ifdef SEQ_DIV4_SIGNED_EN
          quo_d = neg_quo_q ? -quo_raw : quo_raw;
          rem_d = neg_rem_q ? -rem_raw : rem_raw;
`else
          quo_d = quo_raw;
          rem_d = rem_raw;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A zero divisor reaches DONE without iterating; publish its result here.
        if (dvr_q == '0) begin
          quo_d  = DVD_W'(DBZ_QUOTIENT);
          rem_d  = dq_q[DVR_W-1:0];
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
    dq_q  <= dq_d;
    pr_q  <= pr_d;
    dvr_q <= dvr_d;
`ifdef SEQ_DIV4_SIGNED_EN
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
`endif
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_div4.sv
// Scoreboard bench for seq_div4: directed cases plus a random sweep against an
// arithmetic reference model; signed cases only when SEQ_DIV4_SIGNED_EN is set.
module tb_seq_div4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
`ifdef SEQ_DIV4_SIGNED_EN
  logic       signed_mode;
`endif
  logic       busy, done, dbz;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         edge_no;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] prev_q;
  logic [3:0] prev_r;

  seq_div4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef SEQ_DIV4_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division; SV '/' and '%' truncate toward zero.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b, input logic s);
    exp_t e;
    int   sa, sbv, qq, rr;
    e.edge_no = 0;
    if (b == 4'd0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
      e.z = 1'b1;
    end else if (s) begin
      sa  = $signed(a);
      sbv = $signed(b);
      qq  = sa / sbv;
      rr  = sa % sbv;
      e.q = qq[7:0];
      e.r = rr[3:0];
      e.z = 1'b0;
    end else begin
      qq  = int'(a) / int'(b);
      rr  = int'(a) % int'(b);
      e.q = qq[7:0];
      e.r = rr[3:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("dbz", dbz, mon_e.z);
        check("done_edge", edge_cnt, mon_e.edge_no);
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic s,
                        input int inject_at, input int abort_at);
    exp_t e;
    int   bc;
    int   lat;
    bit   seen;
    e   = model(a, b, s);
    lat = (b == 4'd0) ? 1 : 8;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
`ifdef SEQ_DIV4_SIGNED_EN
    signed_mode = s;
`endif
    @(posedge clk);
    #1;
    start     = 1'b0;
    e.edge_no = edge_cnt + lat;
    sb.push_back(e);
    bc   = busy ? 1 : 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (i == inject_at) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd3;
      end
      if (i == abort_at) rst_n = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (i == abort_at) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        rst_n = 1'b1;
        void'(sb.pop_back());
        prev_q = 8'd0;
        prev_r = 4'd0;
        return;
      end
      if (busy) bc++;
      if (done) seen = 1'b1;
      else begin
        check("held_quotient", quotient, prev_q);
        check("held_remainder", remainder, prev_r);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1");
      sb.delete();
    end
    check("busy_cycles", bc, (lat == 8) ? 8 : 0);
    prev_q = e.q;
    prev_r = e.r;
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra;
    logic [3:0] rb;
    logic       rs;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
`ifdef SEQ_DIV4_SIGNED_EN
    signed_mode = 1'b0;
`endif
    prev_q = 8'd0;
    prev_r = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", dbz, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);

    rst_n = 1'b1;
    run_op(8'd100, 4'd7, 1'b0, 0, 0);
    run_op(8'd200, 4'd15, 1'b0, 0, 0);
    run_op(8'd255, 4'd1, 1'b0, 0, 0);
    run_op(8'd55, 4'd0, 1'b0, 0, 0);
    run_op(8'd100, 4'd7, 1'b0, 4, 0);
    run_op(8'd100, 4'd7, 1'b0, 0, 5);
    run_op(8'd9, 4'd3, 1'b0, 0, 0);
`ifdef SEQ_DIV4_SIGNED_EN
    run_op(8'h9C, 4'd7, 1'b1, 0, 0);
    run_op(8'h80, 4'hF, 1'b1, 0, 0);
`endif
    for (int n = 0; n < 60; n++) begin
      ra = 8'($urandom);
      rb = 4'($urandom_range(0, 15));
`ifdef SEQ_DIV4_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
